// File: rtl/sram_burst_bridge.sv
// Burst request/write/response bus to single-beat SRAM port bridge.
// Read beats return through a 2-entry buffer, so r_ready back-pressure stalls issue without losing data.
module sram_burst_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    r_last,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    b_err,
  output logic                    sram_en,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH/8-1:0] sram_wmask,
  output logic [1:0]              sram_size,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH:0]      beat_cnt;
  logic                    inflight;
  logic                    inflight_last;
  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic [1:0]              fifo_last;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              occ;
  logic                    err_acc;
  logic                    b_err_q;

  logic                    pop;
  logic [2:0]              load;
  logic                    rd_issue;
  logic                    w_beat;
  logic                    last_idx;
  logic [ADDR_WIDTH-1:0]   addr_step;

  assign req_ready = (state == IDLE);
  assign w_ready   = (state == WRITE);
  assign b_valid   = (state == WRESP);
  assign b_err     = b_err_q;

  assign r_valid   = (occ != 2'd0);
  assign r_data    = r_valid ? fifo_data[rd_ptr] : '0;
  assign r_last    = r_valid & fifo_last[rd_ptr];
  assign pop       = r_valid & r_ready;

  // Buffered plus in-flight beats, net of this cycle's pop, must leave room for one more.
  assign load      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign last_idx  = (beat_cnt == {1'b0, len_q});
  assign rd_issue  = (state == READ) && (beat_cnt <= {1'b0, len_q}) && (load < 3'd2);
  assign w_beat    = (state == WRITE) && w_valid;
  assign addr_step = ADDR_WIDTH'(1) << size_q;

  always_comb begin
    sram_en    = 1'b0;
    sram_addr  = addr_q;
    sram_wmask = '0;
    sram_size  = size_q;
    sram_wdata = '0;
    if (rd_issue) begin
      sram_en = 1'b1;
    end
    if (w_beat) begin
      sram_en    = |w_strb;
      sram_wmask = w_strb;
      sram_wdata = w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      size_q        <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= '0;
      err_acc       <= 1'b0;
      b_err_q       <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && last_idx;
      if (inflight) begin
        fifo_data[wr_ptr] <= sram_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            len_q    <= req_len;
            beat_cnt <= '0;
            err_acc  <= 1'b0;
            state    <= req_write ? WRITE : READ;
          end
        end
        READ: begin
          if (rd_issue) begin
            addr_q   <= addr_q + addr_step;
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (pop && fifo_last[rd_ptr]) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (w_valid) begin
            addr_q   <= addr_q + addr_step;
            beat_cnt <= beat_cnt + 1'b1;
            if (last_idx) begin
              b_err_q <= err_acc | ~w_last;
              state   <= WRESP;
            end else begin
              err_acc <= err_acc | w_last;
            end
          end
        end
        WRESP: begin
          if (b_ready) begin
            b_err_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_bridge.sv
// Directed bench for sram_burst_bridge: behavioural SRAM with one-cycle read latency plus access logs.
module tb_sram_burst_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_len;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_last;
  logic        b_valid;
  logic        b_ready;
  logic        b_err;
  logic        sram_en;
  logic [31:0] sram_addr;
  logic [3:0]  sram_wmask;
  logic [1:0]  sram_size;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  sram_burst_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_wmask(sram_wmask),
    .sram_size(sram_size), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // SRAM model and access logs
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [3:0]  wr_mask_log[$];
  logic [31:0] wr_data_log[$];
  int          outstanding = 0;
  int          max_out = 0;
  int          mon_next;

  initial sram_rdata = '0;

  assign mon_next = outstanding + ((sram_en && sram_wmask == 4'h0) ? 1 : 0) - ((r_valid && r_ready) ? 1 : 0);

  always @(posedge clk) begin
    if (sram_en && sram_wmask == 4'h0) begin
      sram_rdata <= mdata(sram_addr);
      rd_log.push_back(sram_addr);
    end
    if (sram_en && sram_wmask != 4'h0) begin
      wr_addr_log.push_back(sram_addr);
      wr_mask_log.push_back(sram_wmask);
      wr_data_log.push_back(sram_wdata);
    end
    if (rst) begin
      outstanding <= 0;
    end else begin
      outstanding <= mon_next;
      if (mon_next > max_out) max_out <= mon_next;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a read burst and drain it; r_ready held low for 'stall' cycles, then toggled or held high.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [3:0] len, input int stall, input bit toggle);
    int base;
    int beats;
    logic [31:0] ea;
    base      = rd_log.size();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_size  = size;
    req_len   = len;
    #1;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 60 && beats <= int'(len); c++) begin
      r_ready = (c < stall) ? 1'b0 : (toggle ? ((c % 2) == 0) : 1'b1);
      #1;
      if (r_valid && r_ready) begin
        ea = addr + (32'(beats) << size);
        chk($sformatf("%s_data%0d", tag, beats), r_data, mdata(ea));
        chk($sformatf("%s_last%0d", tag, beats), r_last, (beats == int'(len)));
        beats++;
      end
      cyc();
    end
    r_ready = 1'b0;
    chk({tag, "_beats"}, beats, 64'(len) + 1);
    chk({tag, "_issued"}, rd_log.size() - base, 64'(len) + 1);
    for (int k = 0; k <= int'(len) && base + k < rd_log.size(); k++) begin
      ea = addr + (32'(k) << size);
      chk($sformatf("%s_addr%0d", tag, k), rd_log[base + k], ea);
    end
    chk({tag, "_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
    r_ready = 1'b0; b_ready = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_last", r_last, 1'b0);
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_b_err", b_err, 1'b0);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_sram_wmask", sram_wmask, 4'h0);
    rst = 1'b0;
    cyc();
    chk("rst_req_ready", req_ready, 1'b1);

    // Single read, cycle-exact latency
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_len = 4'd0;
    r_ready = 1'b1;
    #1;
    chk("r1_req_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    #1;
    chk("r1_en_t1", sram_en, 1'b1);
    chk("r1_addr_t1", sram_addr, 32'h100);
    chk("r1_wmask_t1", sram_wmask, 4'h0);
    chk("r1_size_t1", sram_size, 2'd2);
    chk("r1_rvalid_t1", r_valid, 1'b0);
    cyc();
    chk("r1_en_t2", sram_en, 1'b0);
    chk("r1_rvalid_t2", r_valid, 1'b0);
    cyc();
    chk("r1_rvalid_t3", r_valid, 1'b1);
    chk("r1_rdata_t3", r_data, 32'hA5A5_5B5A);
    chk("r1_rlast_t3", r_last, 1'b1);
    cyc();
    chk("r1_rvalid_t4", r_valid, 1'b0);
    chk("r1_idle_t4", req_ready, 1'b1);
    r_ready = 1'b0;

    // 4-beat read with stall then toggling r_ready
    run_read("r4", 32'h200, 2'd2, 4'd3, 5, 1'b1);
    // Sustained-rate read and byte-size stepping
    run_read("rb", 32'h10, 2'd0, 4'd2, 0, 1'b0);
    // Address wrap at the top of the space
    base = rd_log.size();
    run_read("rw", 32'hFFFF_FFFC, 2'd2, 4'd1, 0, 1'b0);
    if (rd_log.size() >= base + 2) chk("rw_wrap_addr", rd_log[base + 1], 32'h0);
    else chk("rw_wrap_count", rd_log.size() - base, 2);

    // 3-beat write with a zero-strobe middle beat
    base = wr_addr_log.size();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_size = 2'd2; req_len = 4'd2;
    cyc();
    req_valid = 1'b0;
    #1;
    chk("w3_w_ready", w_ready, 1'b1);
    w_valid = 1'b1; w_data = 32'h1111_1111; w_strb = 4'hF; w_last = 1'b0;
    #1;
    chk("w3_b0_en", sram_en, 1'b1);
    chk("w3_b0_addr", sram_addr, 32'h300);
    chk("w3_b0_wmask", sram_wmask, 4'hF);
    chk("w3_b0_wdata", sram_wdata, 32'h1111_1111);
    cyc();
    w_data = 32'h2222_2222; w_strb = 4'h0;
    #1;
    chk("w3_b1_en", sram_en, 1'b0);
    chk("w3_b1_wmask", sram_wmask, 4'h0);
    cyc();
    w_data = 32'h3333_3333; w_strb = 4'h3; w_last = 1'b1;
    #1;
    chk("w3_b2_en", sram_en, 1'b1);
    chk("w3_b2_addr", sram_addr, 32'h308);
    chk("w3_b2_wmask", sram_wmask, 4'h3);
    cyc();
    w_valid = 1'b0; w_last = 1'b0; w_strb = 4'h0;
    #1;
    chk("w3_b_valid", b_valid, 1'b1);
    chk("w3_b_err", b_err, 1'b0);
    chk("w3_resp_w_ready", w_ready, 1'b0);
    chk("w3_resp_en", sram_en, 1'b0);
    chk("w3_nwrites", wr_addr_log.size() - base, 2);
    if (wr_addr_log.size() >= base + 2) begin
      chk("w3_log_a1", wr_addr_log[base + 1], 32'h308);
      chk("w3_log_m1", wr_mask_log[base + 1], 4'h3);
      chk("w3_log_d1", wr_data_log[base + 1], 32'h3333_3333);
    end
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
    #1;
    chk("w3_b_done", b_valid, 1'b0);
    chk("w3_idle", req_ready, 1'b1);

    // 2-beat write, early w_last, idle gap between beats, b_ready held off
    base = wr_addr_log.size();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h400; req_size = 2'd2; req_len = 4'd1;
    cyc();
    req_valid = 1'b0;
    w_valid = 1'b1; w_data = 32'hAAAA_0001; w_strb = 4'hF; w_last = 1'b1;
    cyc();
    w_valid = 1'b0; w_last = 1'b0;
    #1;
    chk("w2_gap_en", sram_en, 1'b0);
    chk("w2_gap_bvalid", b_valid, 1'b0);
    cyc();
    w_valid = 1'b1; w_data = 32'hAAAA_0002; w_strb = 4'hF; w_last = 1'b0;
    #1;
    chk("w2_b1_addr", sram_addr, 32'h404);
    cyc();
    w_valid = 1'b0; w_strb = 4'h0;
    #1;
    chk("w2_b_valid", b_valid, 1'b1);
    chk("w2_b_err", b_err, 1'b1);
    chk("w2_nwrites", wr_addr_log.size() - base, 2);
    cyc();
    cyc();
    chk("w2_b_hold", b_valid, 1'b1);
    chk("w2_err_hold", b_err, 1'b1);
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
    #1;
    chk("w2_b_done", b_valid, 1'b0);
    chk("w2_err_clr", b_err, 1'b0);

    // Reset in the middle of a 4-beat read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h600; req_size = 2'd2; req_len = 4'd3;
    r_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mr_sram_en", sram_en, 1'b0);
    chk("mr_r_valid", r_valid, 1'b0);
    chk("mr_req_ready", req_ready, 1'b1);
    base = rd_log.size();
    cyc();
    cyc();
    chk("mr_no_access", rd_log.size() - base, 0);
    run_read("mr_next", 32'h500, 2'd2, 4'd1, 0, 1'b0);

    chk("max_outstanding_le2", (max_out <= 2), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
